multi_cycle_controller: RTL and testbench

// Moore FSM sequencing a multi-cycle MIPS datapath (shared memory, IR, A/B/ALUOut regs) for R-type, LW, SW, BEQ, J.

---
 rtl/multi_cycle_controller_pkg.sv | 49 ++++
 rtl/multi_cycle_controller_ctrl_decode.sv | 76 +++++++
 rtl/multi_cycle_controller.sv | 118 +++++++++++
 tb/tb_multi_cycle_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes, opcodes,
// mux-select encodings and the opcode -> instruction-type classifier.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ERR    = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // inst_type bit positions: {R, LW, SW, BEQ, J}
  localparam int ITYPE_LW = 3;

  function automatic logic [4:0] opcode_type(input logic [5:0] op);
    case (op)
      OP_RTYPE: opcode_type = 5'b10000;
      OP_LW:    opcode_type = 5'b01000;
      OP_SW:    opcode_type = 5'b00100;
      OP_BEQ:   opcode_type = 5'b00010;
      OP_J:     opcode_type = 5'b00001;
      default:  opcode_type = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller_ctrl_decode.sv
// Combinational state -> control word. Strobes leave here ungated; the top
// qualifies them with step and reset.
module multi_cycle_controller_ctrl_decode
  import multi_cycle_controller_pkg::*;
(
  input  logic [3:0] state,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_t'(state))
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: i_or_d = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = PCS_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_source = PCS_JUMP;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore controller for a multi-cycle MIPS datapath: state register, next-state,
// step/reset gating of write strobes, and debug cycle/instruction counters.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic [5:0]       opcode,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [4:0]       inst_type,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [4:0]       inst_type_q, type_d;
  logic [CNT_W-1:0] cycle_q, instr_q;
  logic             is_final, step_en;
  logic             pc_write_raw, pc_write_cond_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  multi_cycle_controller_ctrl_decode u_decode (
    .state         (state_q),
    .pc_write      (pc_write_raw),
    .pc_write_cond (pc_write_cond_raw),
    .i_or_d        (i_or_d),
    .mem_write     (mem_write_raw),
    .ir_write      (ir_write_raw),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write_raw),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source)
  );

  assign type_d = opcode_type(opcode);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:    state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:      state_d = S_BRANCH;
          OP_J:        state_d = S_JUMP;
          default:     state_d = HALT_ON_ILLEGAL ? S_ERR : S_FETCH;
        endcase
      end
      S_MEMADR: state_d = inst_type_q[ITYPE_LW] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_ERR;
    endcase
  end

  // An illegal opcode treated as a NOP retires straight out of DECODE.
  always_comb begin
    case (state_q)
      S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP: is_final = 1'b1;
      S_DECODE: is_final = !HALT_ON_ILLEGAL && (type_d == 5'b00000);
      default:  is_final = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      inst_type_q <= 5'b00000;
      cycle_q     <= '0;
      instr_q     <= '0;
    end else if (step) begin
      state_q <= state_d;
      if (state_q == S_DECODE) inst_type_q <= type_d;
      if (state_q != S_ERR)    cycle_q     <= cycle_q + CNT_ONE;
      if (is_final)            instr_q     <= instr_q + CNT_ONE;
    end
  end

  // Reset is folded in combinationally so strobes drop without waiting for an edge.
  assign step_en       = step & ~reset;
  assign pc_write      = pc_write_raw      & step_en;
  assign pc_write_cond = pc_write_cond_raw & step_en;
  assign mem_write     = mem_write_raw     & step_en;
  assign ir_write      = ir_write_raw      & step_en;
  assign reg_write     = reg_write_raw     & step_en;
  assign instr_done    = is_final          & step_en;

  assign state       = state_q;
  assign inst_type   = inst_type_q;
  assign illegal     = (state_q == S_ERR);
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: directed scenarios plus a randomized
// instruction stream checked against a path/table model of the controller.
module tb_multi_cycle_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        step = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        pc_write, pc_write_cond, i_or_d, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [4:0]  inst_type;
  logic        illegal, instr_done;
  logic [15:0] cycle_count, instr_count;
  logic [14:0] ctl;

  int checks = 0;
  int errors = 0;

  multi_cycle_controller #(.CNT_W(16), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clock(clock), .reset(reset), .step(step), .opcode(opcode),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .inst_type(inst_type), .illegal(illegal),
    .instr_done(instr_done), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  localparam logic [14:0] STROBES = 15'b110_1100_1000_0000;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;

  // Reference model: current state, remaining states of the instruction, counters.
  int          m_state;
  int          m_rest[$];
  logic [4:0]  m_type;
  logic [15:0] m_cyc, m_inst;

  function automatic logic [14:0] exp_ctl(input int s, input logic stp);
    logic [14:0] w;
    w = '0;
    case (s)
      0:  begin w[14] = 1'b1; w[10] = 1'b1; w[5:4] = 2'b01; end
      1:  w[5:4] = 2'b11;
      2:  begin w[6] = 1'b1; w[5:4] = 2'b10; end
      3:  w[12] = 1'b1;
      4:  begin w[8] = 1'b1; w[7] = 1'b1; end
      5:  begin w[12] = 1'b1; w[11] = 1'b1; end
      6:  begin w[6] = 1'b1; w[3:2] = 2'b10; end
      7:  begin w[9] = 1'b1; w[7] = 1'b1; end
      8:  begin w[6] = 1'b1; w[3:2] = 2'b01; w[1:0] = 2'b01; w[13] = 1'b1; end
      9:  begin w[1:0] = 2'b10; w[14] = 1'b1; end
      default: w = '0;
    endcase
    if (!stp) w = w & ~STROBES;
    return w;
  endfunction

  function automatic logic m_final();
    return (m_rest.size() == 0) && (m_state > 1) && (m_state != 10);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_rest.delete();
    m_type = 5'b0;
    m_cyc = 16'd0;
    m_inst = 16'd0;
  endtask

  task automatic model_step();
    if (m_state == 10) return;
    m_cyc = m_cyc + 16'd1;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      m_rest.delete();
      case (opcode)
        OP_R:    begin m_type = 5'b10000; m_rest.push_back(6); m_rest.push_back(7); end
        OP_LW:   begin m_type = 5'b01000; m_rest.push_back(2); m_rest.push_back(3); m_rest.push_back(4); end
        OP_SW:   begin m_type = 5'b00100; m_rest.push_back(2); m_rest.push_back(5); end
        OP_BEQ:  begin m_type = 5'b00010; m_rest.push_back(8); end
        OP_J:    begin m_type = 5'b00001; m_rest.push_back(9); end
        default: begin m_type = 5'b00000; m_rest.push_back(10); end
      endcase
      m_state = m_rest.pop_front();
    end else if (m_rest.size() == 0) begin
      m_state = 0;
      m_inst = m_inst + 16'd1;
    end else begin
      m_state = m_rest.pop_front();
    end
  endtask

  task automatic arm(input logic [5:0] op);
    @(negedge clock);
    step = 1'b1;
    opcode = op;
    #1;
  endtask

  task automatic commit();
    @(posedge clock);
    #1;
    model_step();
    step = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step = 1'b0; opcode = 6'd0;
    model_reset();
    #12;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (ctl !== exp_ctl(0, 1'b0)) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, exp_ctl(0, 1'b0)); end
    checks++; if ({cycle_count, instr_count} !== 32'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", cycle_count, instr_count); end
    checks++; if ({inst_type, illegal, instr_done} !== 7'd0) begin errors++; $display("FAIL reset_flags got %b exp 0", {inst_type, illegal, instr_done}); end
    step = 1'b1;
    #1;
    checks++; if (ctl !== exp_ctl(0, 1'b0)) begin errors++; $display("FAIL reset_dominates_step got %b exp %b", ctl, exp_ctl(0, 1'b0)); end
    step = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    for (int i = 0; i < 4; i++) begin
      arm(OP_R);
      checks++; if (state !== 4'(m_state)) begin errors++; $display("FAIL rtype_state step %0d got %0d exp %0d", i, state, m_state); end
      checks++; if (ctl !== exp_ctl(m_state, 1'b1)) begin errors++; $display("FAIL rtype_ctl step %0d got %b exp %b", i, ctl, exp_ctl(m_state, 1'b1)); end
      checks++; if (instr_done !== m_final()) begin errors++; $display("FAIL rtype_done step %0d got %b exp %b", i, instr_done, m_final()); end
      commit();
    end
    checks++; if ({state, instr_count, cycle_count} !== {4'd0, 16'd1, 16'd4}) begin errors++; $display("FAIL rtype_end got st %0d ic %0d cc %0d exp 0 1 4", state, instr_count, cycle_count); end
  endtask

  task automatic test_lw();
    for (int i = 0; i < 5; i++) begin
      arm(OP_LW);
      checks++; if (state !== 4'(m_state)) begin errors++; $display("FAIL lw_state step %0d got %0d exp %0d", i, state, m_state); end
      checks++; if (ctl !== exp_ctl(m_state, 1'b1)) begin errors++; $display("FAIL lw_ctl step %0d got %b exp %b", i, ctl, exp_ctl(m_state, 1'b1)); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL lw_no_memwrite step %0d got %b exp 0", i, mem_write); end
      commit();
      if (i == 1) begin
        checks++; if (inst_type !== 5'b01000) begin errors++; $display("FAIL lw_inst_type got %b exp 01000", inst_type); end
      end
    end
    checks++; if ({state, instr_count, cycle_count} !== {4'd0, m_inst, m_cyc}) begin errors++; $display("FAIL lw_end got st %0d ic %0d cc %0d exp 0 %0d %0d", state, instr_count, cycle_count, m_inst, m_cyc); end
  endtask

  task automatic test_branch_jump();
    logic [5:0] ops[2];
    ops[0] = OP_BEQ;
    ops[1] = OP_J;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        arm(ops[k]);
        checks++; if (state !== 4'(m_state)) begin errors++; $display("FAIL bj_state op %0d step %0d got %0d exp %0d", k, i, state, m_state); end
        checks++; if (ctl !== exp_ctl(m_state, 1'b1)) begin errors++; $display("FAIL bj_ctl op %0d step %0d got %b exp %b", k, i, ctl, exp_ctl(m_state, 1'b1)); end
        checks++; if (instr_done !== m_final()) begin errors++; $display("FAIL bj_done op %0d step %0d got %b exp %b", k, i, instr_done, m_final()); end
        commit();
      end
      checks++; if ({state, instr_count} !== {4'd0, m_inst}) begin errors++; $display("FAIL bj_end op %0d got st %0d ic %0d exp 0 %0d", k, state, instr_count, m_inst); end
    end
  endtask

  task automatic test_sw_hold();
    for (int i = 0; i < 3; i++) begin
      arm(OP_SW);
      commit();
    end
    checks++; if (state !== 4'd5) begin errors++; $display("FAIL sw_reach_memwr got %0d exp 5", state); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      checks++; if ({state, mem_write, cycle_count, instr_count} !== {4'd5, 1'b0, m_cyc, m_inst}) begin
        errors++; $display("FAIL sw_hold clk %0d got st %0d mw %b cc %0d ic %0d exp 5 0 %0d %0d", i, state, mem_write, cycle_count, instr_count, m_cyc, m_inst);
      end
    end
    arm(OP_SW);
    checks++; if ({mem_write, instr_done} !== 2'b11) begin errors++; $display("FAIL sw_pulse got %b exp 11", {mem_write, instr_done}); end
    commit();
    checks++; if ({state, mem_write, instr_count} !== {4'd0, 1'b0, m_inst}) begin errors++; $display("FAIL sw_after got st %0d mw %b ic %0d exp 0 0 %0d", state, mem_write, instr_count, m_inst); end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 2; i++) begin
      arm(OP_BAD);
      commit();
    end
    checks++; if ({state, illegal, inst_type} !== {4'd10, 1'b1, 5'b0}) begin errors++; $display("FAIL err_enter got st %0d ill %b it %b exp 10 1 0", state, illegal, inst_type); end
    for (int i = 0; i < 20; i++) begin
      arm(6'($urandom_range(0, 63)));
      checks++; if ({state, illegal, ctl, instr_done} !== {4'd10, 1'b1, 15'd0, 1'b0}) begin
        errors++; $display("FAIL err_hold step %0d got st %0d ill %b ctl %b done %b", i, state, illegal, ctl, instr_done);
      end
      commit();
    end
    checks++; if ({cycle_count, instr_count} !== {m_cyc, m_inst}) begin errors++; $display("FAIL err_frozen got %0d/%0d exp %0d/%0d", cycle_count, instr_count, m_cyc, m_inst); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++; if ({state, illegal, cycle_count, instr_count} !== {4'd0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL err_reset got st %0d ill %b cc %0d ic %0d exp 0 0 0 0", state, illegal, cycle_count, instr_count);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      arm(OP_SW);
      commit();
    end
    arm(OP_SW);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL mid_pre got mw %b exp 1", mem_write); end
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if ({mem_write, state, instr_done} !== {1'b0, 4'd0, 1'b0}) begin errors++; $display("FAIL mid_reset got mw %b st %0d done %b exp 0 0 0", mem_write, state, instr_done); end
    checks++; if (ctl !== exp_ctl(0, 1'b0)) begin errors++; $display("FAIL mid_reset_ctl got %b exp %b", ctl, exp_ctl(0, 1'b0)); end
    step = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] legal[5];
    legal[0] = OP_R; legal[1] = OP_LW; legal[2] = OP_SW; legal[3] = OP_BEQ; legal[4] = OP_J;
    for (int i = 0; i < 300; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(negedge clock);
        #1;
        checks++; if ({state, ctl & STROBES, instr_done} !== {4'(m_state), 15'd0, 1'b0}) begin
          errors++; $display("FAIL rnd_idle %0d got st %0d strobes %b done %b exp st %0d", i, state, ctl & STROBES, instr_done, m_state);
        end
      end
      arm(legal[$urandom_range(0, 4)]);
      checks++; if (state !== 4'(m_state)) begin errors++; $display("FAIL rnd_state %0d got %0d exp %0d", i, state, m_state); end
      checks++; if (ctl !== exp_ctl(m_state, 1'b1)) begin errors++; $display("FAIL rnd_ctl %0d got %b exp %b", i, ctl, exp_ctl(m_state, 1'b1)); end
      checks++; if (instr_done !== m_final()) begin errors++; $display("FAIL rnd_done %0d got %b exp %b", i, instr_done, m_final()); end
      commit();
      checks++; if ({inst_type, cycle_count, instr_count} !== {m_type, m_cyc, m_inst}) begin
        errors++; $display("FAIL rnd_regs %0d got it %b cc %0d ic %0d exp %b %0d %0d", i, inst_type, cycle_count, instr_count, m_type, m_cyc, m_inst);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_branch_jump();
    test_sw_hold();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
